mac_pe: RTL and testbench
=========================

Name: mac_pe

Overview:
Signed multiply-accumulate processing element for the systolic MAC array. Accepts one 8-bit signed operand pair per valid pulse and multiplies it sequentially (one partial-product bit per cycle). Adds the product into a 32-bit running accumulator and pulses done when the result is ready. Forwards the accepted operands to the east/south neighbour PE with a valid_out strobe.

Parameters:
DATA_W, 8, operand width (A_in, B_in, A_out, B_out)
ACC_W, 32, accumulator/result width (y_out); must be >= 2*DATA_W

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
valid  input  1  operand pair on A_in/B_in is presented this cycle
A_in  input  DATA_W  signed multiplicand (two's complement)
B_in  input  DATA_W  signed multiplier (two's complement)
y_out  output  ACC_W  signed accumulated sum of products, registered
A_out  output  DATA_W  registered copy of last accepted A_in (bit pattern)
B_out  output  DATA_W  registered copy of last accepted B_in (bit pattern)
done  output  1  one-cycle pulse: y_out just updated with the new product
valid_out  output  1  one-cycle pulse: A_out/B_out hold a newly accepted pair

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (sampled at a clk rise): y_out=0, A_out=0, B_out=0, done=0, valid_out=0, FSM=IDLE, all internal product/counter registers cleared. Reset aborts any multiply in progress; the partial product is discarded and the accumulator is not updated.
- FSM states: IDLE, MUL, ACC.
- IDLE: at an edge with valid=1, latch A_in/B_in into internal operand registers, load A_out/B_out, set valid_out=1 for the next cycle, clear the product register, load the bit counter with DATA_W, go to MUL. With valid=0, remain in IDLE.
- MUL: lasts exactly DATA_W cycles, one multiplier bit per cycle. Any algorithm is allowed (shift-add on magnitudes with sign fix, or radix-2 Booth) provided the result equals the exact 2*DATA_W-bit signed product. -128*-128 = +16384 must be exact. After the last iteration, go to ACC.
- ACC: one cycle. At its closing edge, y_out <= y_out + sign-extend(product) using ACC_W-bit two's-complement wrap-around (no saturation, no overflow flag). done=1 for exactly the following cycle. FSM returns to IDLE.
- Latency: if the pair is accepted at edge T, y_out updates and done rises at edge T+DATA_W+1 (T+9 by default). done falls at T+DATA_W+2.
- valid_out: high for exactly one cycle after the acceptance edge; 0 otherwise. A_out/B_out hold their value until the next acceptance.
- valid while in MUL or ACC is ignored: not queued, and A_out/B_out/valid_out are unchanged.
- valid=1 in the cycle done is high (FSM back in IDLE) is accepted normally. Back-to-back throughput is one pair per DATA_W+1 cycles.
- The accumulator is never cleared except by reset. Successive products sum across operations.
- All outputs are driven directly from registers (no combinational input-to-output path).

Test Plan:
- Reset: hold reset 2 cycles with valid=1 and A_in=5, B_in=5 -> all outputs 0, no done, no valid_out; after release with valid=0, outputs stay 0.
- Accumulating sequence, one pulse each, waiting for done: (10,2),(-20,3),(30,-4),(-40,5),(50,-6),(-60,7),(70,-8) -> y_out after each done is 20, -40, -160, -360, -660, -1080, -1640. done is high exactly 1 cycle, 9 cycles after acceptance.
- Forwarding: accept (-20,3) -> next cycle valid_out=1, A_out=8'hEC, B_out=8'h03. Both hold after valid_out drops and after done.
- Extremes: from reset, (-128,-128) -> y_out=16384; then (-128,127) -> y_out=16384-16256=128; then (127,127) -> y_out=16257.
- Busy-ignore: accept (3,4); assert valid with (100,100) on cycles 2..8 of MUL -> single done with y_out=12, A_out=3, B_out=4, no second valid_out. Then valid with (2,2) in the done cycle -> accepted, next done gives y_out=16.
- Mid-operation reset: accept (50,50), assert reset at cycle 4 of MUL -> no done ever; y_out=0; a subsequent (1,1) yields y_out=1.

Source files
------------

// File: rtl/mac_pe.sv
// Signed multiply-accumulate PE: sequential shift-add multiply (one multiplier bit per
// cycle), 32-bit wrap-around accumulate, and registered forwarding of accepted operands.
module mac_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid,
    input  logic signed [DATA_W-1:0] A_in,
    input  logic signed [DATA_W-1:0] B_in,
    output logic signed [ACC_W-1:0]  y_out,
    output logic        [DATA_W-1:0] A_out,
    output logic        [DATA_W-1:0] B_out,
    output logic                     done,
    output logic                     valid_out
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

    state_t                    state, state_nxt;
    logic signed [PROD_W-1:0]  mcand;
    logic signed [PROD_W-1:0]  prod;
    logic        [DATA_W-1:0]  mplier;
    logic        [CNT_W-1:0]   cnt;
    logic                      accept;
    logic                      last_bit;

    // The multiplier MSB carries weight -2^(DATA_W-1), so its partial product is subtracted.
    function automatic logic signed [PROD_W-1:0] mul_step(
        input logic signed [PROD_W-1:0] acc,
        input logic signed [PROD_W-1:0] addend,
        input logic                     bit_set,
        input logic                     msb
    );
        if (!bit_set)
            return acc;
        return msb ? (acc - addend) : (acc + addend);
    endfunction

    function automatic logic signed [ACC_W-1:0] acc_wrap(
        input logic signed [ACC_W-1:0]  acc,
        input logic signed [PROD_W-1:0] p
    );
        logic signed [ACC_W-1:0] p_ext;
        p_ext = p;
        return acc + p_ext;
    endfunction

    assign last_bit = (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (valid) begin
                    accept    = 1'b1;
                    state_nxt = MUL;
                end
            end
            MUL: begin
                if (last_bit)
                    state_nxt = ACC;
            end
            ACC:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_out     <= '0;
            A_out     <= '0;
            B_out     <= '0;
            done      <= 1'b0;
            valid_out <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            cnt       <= '0;
        end else begin
            done      <= 1'b0;
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand     <= {{DATA_W{A_in[DATA_W-1]}}, A_in};
                        mplier    <= B_in;
                        prod      <= '0;
                        cnt       <= CNT_W'(DATA_W);
                        A_out     <= A_in;
                        B_out     <= B_in;
                        valid_out <= 1'b1;
                    end
                end
                MUL: begin
                    prod   <= mul_step(prod, mcand, mplier[0], last_bit);
                    mcand  <= mcand <<< 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                end
                ACC: begin
                    y_out <= acc_wrap(y_out, prod);
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_pe.sv
// Bench for mac_pe: cycle-level reference model (timing from acceptance edges, plain
// integer products) checked every cycle, plus table-driven and hand-written sequences.
module tb_mac_pe;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               valid = 1'b0;
    logic signed [7:0]  A_in = '0;
    logic signed [7:0]  B_in = '0;
    logic signed [31:0] y_out;
    logic        [7:0]  A_out;
    logic        [7:0]  B_out;
    logic               done;
    logic               valid_out;

    mac_pe #(.DATA_W(8), .ACC_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .A_in      (A_in),
        .B_in      (B_in),
        .y_out     (y_out),
        .A_out     (A_out),
        .B_out     (B_out),
        .done      (done),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int edge_n = 0;
    int free_at = 0;
    int done_at = -1;
    int acc_edge = -1;
    logic signed [31:0] m_y = '0;
    logic signed [31:0] m_prod = '0;
    logic        [7:0]  m_a = '0;
    logic        [7:0]  m_b = '0;

    typedef struct {
        int a;
        int b;
        int y;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h) at edge %0d",
                     name, $signed(act), act, $signed(exp), exp, edge_n);
        end
    endtask

    // Apply one cycle of inputs, advance the model by one edge and compare all outputs.
    task automatic step(input logic v, input int a, input int b, input logic r);
        valid = v;
        A_in  = a[7:0];
        B_in  = b[7:0];
        reset = r;
        @(posedge clk);
        edge_n++;
        if (r) begin
            m_y      = '0;
            m_a      = '0;
            m_b      = '0;
            done_at  = -1;
            acc_edge = -1;
            free_at  = edge_n + 1;
        end else begin
            if (edge_n == done_at)
                m_y = m_y + m_prod;
            if (v && edge_n >= free_at) begin
                m_a      = A_in;
                m_b      = B_in;
                m_prod   = int'(A_in) * int'(B_in);
                acc_edge = edge_n;
                done_at  = edge_n + 9;
                free_at  = edge_n + 10;
            end
        end
        #1;
        chk("y_out", y_out, m_y);
        chk("A_out", 32'(A_out), 32'(m_a));
        chk("B_out", 32'(B_out), 32'(m_b));
        chk("done", 32'(done), 32'(edge_n == done_at));
        chk("valid_out", 32'(valid_out), 32'(edge_n == acc_edge));
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 0, 0, 1'b0);
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n < 0)
            chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic op(input int a, input int b);
        int lat;
        step(1'b1, a, b, 1'b0);
        wait_done(lat);
        chk("done_latency", 32'(lat), 32'd9);
    endtask

    initial begin
        int n;
        int done_cnt;
        int vo_cnt;

        tbl[0] = '{a: 10,  b: 2,  y: 20};
        tbl[1] = '{a: -20, b: 3,  y: -40};
        tbl[2] = '{a: 30,  b: -4, y: -160};
        tbl[3] = '{a: -40, b: 5,  y: -360};
        tbl[4] = '{a: 50,  b: -6, y: -660};
        tbl[5] = '{a: -60, b: 7,  y: -1080};
        tbl[6] = '{a: 70,  b: -8, y: -1640};

        // Reset held with live operands, then idle
        step(1'b1, 5, 5, 1'b1);
        step(1'b1, 5, 5, 1'b1);
        chk("reset_y", y_out, 32'd0);
        chk("reset_vo", 32'(valid_out), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0);
        chk("post_reset_y", y_out, 32'd0);

        // Accumulating sequence
        for (int i = 0; i < 7; i++) begin
            op(tbl[i].a, tbl[i].b);
            chk("acc_seq", y_out, 32'(tbl[i].y));
        end

        // Extremes
        step(1'b0, 0, 0, 1'b1);
        op(-128, -128);
        chk("ext_m128_m128", y_out, 32'd16384);
        op(-128, 127);
        chk("ext_m128_127", y_out, 32'd128);
        op(127, 127);
        chk("ext_127_127", y_out, 32'd16257);

        // Forwarding
        step(1'b1, -20, 3, 1'b0);
        chk("fwd_vo", 32'(valid_out), 32'd1);
        chk("fwd_A", 32'(A_out), 32'h0000_00EC);
        chk("fwd_B", 32'(B_out), 32'h0000_0003);
        step(1'b0, 0, 0, 1'b0);
        chk("fwd_vo_drop", 32'(valid_out), 32'd0);
        chk("fwd_A_hold", 32'(A_out), 32'h0000_00EC);
        wait_done(n);
        chk("fwd_A_after_done", 32'(A_out), 32'h0000_00EC);
        chk("fwd_B_after_done", 32'(B_out), 32'h0000_0003);

        // Busy-ignore, then acceptance in the done cycle
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 3, 4, 1'b0);
        vo_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 100, 100, 1'b0);
            if (valid_out === 1'b1) vo_cnt++;
        end
        wait_done(n);
        chk("busy_lat", 32'(n), 32'd2);
        chk("busy_vo", 32'(vo_cnt), 32'd0);
        chk("busy_y", y_out, 32'd12);
        chk("busy_A", 32'(A_out), 32'd3);
        chk("busy_B", 32'(B_out), 32'd4);
        op(2, 2);
        chk("done_cycle_accept_y", y_out, 32'd16);

        // Reset in the middle of a multiply
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 50, 50, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b1);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 0, 0, 1'b0);
            if (done === 1'b1) done_cnt++;
        end
        chk("midreset_done", 32'(done_cnt), 32'd0);
        chk("midreset_y", y_out, 32'd0);
        op(1, 1);
        chk("midreset_then_1x1", y_out, 32'd1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 2) == 0, int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), $urandom_range(0, 80) == 0);
        end
        for (int i = 0; i < 12; i++) step(1'b0, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
